train_check_arbiter: RTL and testbench

Shares one train-permutation checker (the stack/station checker: 4-bit `in_valid`/`data` stream in, one-cycle `out_valid`/`result` out) between `NUM_REQ` requesters. It round-robin arbitrates pending jobs and serializes the granted job into the checker's input protocol: car count first, then target order. It then waits for the verdict and returns it to the owning requester, tagged by a one-hot response strobe. It sits directly in front of the checker. Checker ports connect 1:1 to the `chk_*` ports.

---
 rtl/train_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/train_check_arbiter.sv | 159 +++++++++++++++
 tb/tb_train_check_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/train_arb_pkg.sv
// Shared types and helpers for the train-checker front-end arbiter.
// The optional WAIT watchdog is enabled by defining TRAIN_ARB_TIMEOUT_EN.
package train_arb_pkg;

  localparam int CAR_W        = 4;
  localparam int MAX_CARS_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    RESP
  } state_e;

  // LSB of car `car` of requester `req` inside the flattened req_order bus.
  function automatic int order_lsb(input int req, input int car, input int max_cars);
    return (req * max_cars + car) * CAR_W;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester after the last granted one has top priority.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  int            j;

  // Scan from the farthest offset down so the nearest pending requester wins.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        ptr_d  = PW'((j + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/train_check_arbiter.sv
// Shares one train-permutation checker between NUM_REQ requesters.
// Define TRAIN_ARB_TIMEOUT_EN to add the WAIT-state watchdog (TIMEOUT cycles).
module train_check_arbiter
  import train_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int MAX_CARS = MAX_CARS_DEF
`ifdef TRAIN_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 63
`endif
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*CAR_W-1:0]            req_cnt,
  input  logic [NUM_REQ*MAX_CARS*CAR_W-1:0]   req_order,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic                                rsp_result,
  output logic                                rsp_err,
  output logic                                busy,
  output logic                                chk_in_valid,
  output logic [CAR_W-1:0]                    chk_data,
  input  logic                                chk_out_valid,
  input  logic                                chk_result
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OW  = MAX_CARS * CAR_W;

  state_e           state_q, state_d;
  logic [IDW-1:0]   id_q, id_d, gid;
  logic [CAR_W-1:0] idx_q, idx_d, cnt_q, gcnt;
  logic [OW-1:0]    order_q;
  logic             res_q, res_d, err_q, err_d;
  logic [NUM_REQ-1:0] gnt;
  logic             accept, shift, grant_bad;

`ifdef TRAIN_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) < 6) ? 6 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  always_comb begin
    gid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gid = IDW'(i);
    end
  end

  assign gcnt      = req_cnt[int'(gid)*CAR_W +: CAR_W];
  assign grant_bad = (gcnt == '0) || (int'(gcnt) > MAX_CARS);
  // Gated with rst_n so req_ready stays low while reset is held.
  assign accept    = rst_n && (state_q == IDLE) && (|req_valid);
  assign shift     = (state_q == SEND) && (idx_q != '0);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    idx_d   = idx_q;
    res_d   = res_q;
    err_d   = err_q;
`ifdef TRAIN_ARB_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d    = gid;
          idx_d   = '0;
          res_d   = 1'b0;
          err_d   = grant_bad;
          state_d = grant_bad ? RESP : SEND;
        end
      end
      SEND: begin
        if (idx_q == cnt_q) begin
          state_d = WAIT;
`ifdef TRAIN_ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      WAIT: begin
        if (chk_out_valid) begin
          res_d   = chk_result;
          state_d = RESP;
        end
`ifdef TRAIN_ARB_TIMEOUT_EN
        else if (int'(tmo_q) == TIMEOUT - 1) begin
          res_d   = 1'b0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      idx_q   <= '0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef TRAIN_ARB_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      err_q   <= err_d;
`ifdef TRAIN_ARB_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Job payload: captured at accept, then shifted so car k sits in the low nibble.
  always_ff @(posedge clk) begin
    if (accept) begin
      cnt_q   <= gcnt;
      order_q <= req_order[order_lsb(int'(gid), 0, MAX_CARS) +: OW];
    end else if (shift) begin
      order_q <= order_q >> CAR_W;
    end
  end

  always_comb begin
    req_ready = accept ? gnt : '0;
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[id_q] = 1'b1;
  end

  assign rsp_result   = (state_q == RESP) && res_q;
  assign rsp_err      = (state_q == RESP) && err_q;
  assign busy         = (state_q != IDLE);
  assign chk_in_valid = (state_q == SEND);
  assign chk_data     = (state_q != SEND) ? '0 :
                        (idx_q == '0)     ? cnt_q : order_q[CAR_W-1:0];

endmodule

// File: tb/tb_train_check_arbiter.sv
// Self-checking bench for train_check_arbiter: job-level reference model plus a
// behavioural stack/station checker standing in for the real one.
module tb_train_check_arbiter;

  localparam int N   = 2;
  localparam int MC  = 10;
  localparam int TMO = 63;

  typedef logic [3:0] ord_t [MC];
  typedef struct {
    logic [3:0] cnt;
    ord_t       ord;
  } job_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       req_valid = '0;
  logic [N*4-1:0]     req_cnt = '0;
  logic [N*MC*4-1:0]  req_order = '0;
  logic [N-1:0]       req_ready, rsp_valid;
  logic               rsp_result, rsp_err, busy, chk_in_valid;
  logic [3:0]         chk_data;
  logic               chk_out_valid = 1'b0;
  logic               chk_result = 1'b0;

  always #5 clk = ~clk;

  train_check_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_cnt       (req_cnt),
    .req_order     (req_order),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_result    (rsp_result),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .chk_in_valid  (chk_in_valid),
    .chk_data      (chk_data),
    .chk_out_valid (chk_out_valid),
    .chk_result    (chk_result)
  );

  int n_checks = 0, n_fail = 0, cyc = 0;
  // reference model of the arbiter
  int rr = 0, rsp_at = -1, exp_id = 0, wait_cnt = 0;
  bit job_act = 0, exp_res = 0, exp_err = 0;
  logic [3:0] stream[$];
  // requester agents
  job_t jq[N][$];
  bit   acc_flag[N];
  // observation logs
  int grants[$];
  logic [3:0] dlog[$];
  int ndata = 0, gap_run = 0, min_gap = 1000;
  bit seen_job = 0, prev_civ = 0;
  logic [N-1:0] last_rv = '0;
  bit last_res = 0, last_err = 0;
  // behavioural checker
  logic [3:0] ck_buf[$];
  bit ck_pend = 0, ck_res = 0, stray_en = 0;
  int ck_delay = 0, ck_lat = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stack/station rule: cars 1..c arrive in order; seq[0] is c, seq[1..c] the target order.
  function automatic bit railway(input logic [3:0] seq[$]);
    int stk[$];
    int nxt, c, t;
    c = int'(seq[0]);
    nxt = 1;
    for (int k = 0; k < c; k++) begin
      t = (k + 1 < seq.size()) ? int'(seq[k+1]) : 0;
      while (nxt <= t && nxt <= c) begin
        stk.push_back(nxt);
        nxt++;
      end
      if (stk.size() > 0 && stk[stk.size()-1] == t) void'(stk.pop_back());
      else return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic mon_step();
    logic [N-1:0] exp_rdy, exp_rv;
    logic [3:0] ed, c;
    bit sending, done;
    int g;
    cyc++;
    if (!rst_n) begin
      chk("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_err, busy, chk_in_valid, chk_data}, 0);
      rr = 0; job_act = 0; rsp_at = -1; wait_cnt = 0; stream.delete();
      ck_buf.delete(); ck_pend = 0; prev_civ = 0;
      return;
    end
    exp_rdy = '0;
    g = -1;
    if (!job_act) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(rr + k) % N]) g = (rr + k) % N;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    chk("req_ready", req_ready, exp_rdy);
    sending = stream.size() > 0;
    ed = sending ? stream.pop_front() : 4'd0;
    chk("chk_in_valid", chk_in_valid, sending);
    chk("chk_data", chk_data, ed);
    chk("busy", busy, job_act);
    done = (rsp_at == cyc);
    exp_rv = '0;
    if (done) exp_rv[exp_id] = 1'b1;
    chk("rsp", {rsp_valid, rsp_result, rsp_err}, {exp_rv, done && exp_res, done && exp_err});
    if (rsp_valid != 0) begin
      last_rv = rsp_valid; last_res = rsp_result; last_err = rsp_err;
    end
    if (chk_in_valid) begin
      ndata++;
      dlog.push_back(chk_data);
      if (!prev_civ) begin
        if (seen_job && gap_run < min_gap) min_gap = gap_run;
        seen_job = 1;
      end
      gap_run = 0;
    end else begin
      gap_run++;
    end
    prev_civ = chk_in_valid;
    // waiting for the verdict: every non-sending cycle of an active job with no response scheduled
    if (job_act && !sending && rsp_at < 0) begin
      if (chk_out_valid) begin
        rsp_at = cyc + 1; exp_res = chk_result; exp_err = 0;
      end
`ifdef TRAIN_ARB_TIMEOUT_EN
      else begin
        wait_cnt++;
        if (wait_cnt == TMO) begin
          rsp_at = cyc + 1; exp_res = 0; exp_err = 1;
        end
      end
`endif
    end
    if (done) begin
      job_act = 0; rsp_at = -1;
    end
    if (g >= 0) begin
      grants.push_back(g);
      acc_flag[g] = 1;
      job_act = 1;
      rr = (g + 1) % N;
      exp_id = g;
      wait_cnt = 0;
      c = req_cnt[g*4 +: 4];
      if (c == 0 || c > MC) begin
        rsp_at = cyc + 1; exp_res = 0; exp_err = 1;
      end else begin
        stream.push_back(c);
        for (int k = 0; k < int'(c); k++) stream.push_back(req_order[(g*MC + k)*4 +: 4]);
      end
    end
    if (chk_in_valid) begin
      ck_buf.push_back(chk_data);
      if (ck_buf.size() == int'(ck_buf[0]) + 1) begin
        ck_res = railway(ck_buf);
        ck_pend = 1;
        ck_delay = (ck_lat > 0) ? ck_lat : int'($urandom_range(1, 4));
        ck_buf.delete();
      end
    end
  endtask

  task automatic drive_step();
    job_t j;
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i]) begin
        acc_flag[i] = 0;
        req_valid[i] = 1'b0;
        req_cnt[i*4 +: 4] = 4'($urandom);
        for (int k = 0; k < MC; k++) req_order[(i*MC + k)*4 +: 4] = 4'($urandom);
      end
      if (!req_valid[i] && jq[i].size() > 0) begin
        j = jq[i].pop_front();
        req_cnt[i*4 +: 4] = j.cnt;
        for (int k = 0; k < MC; k++) req_order[(i*MC + k)*4 +: 4] = j.ord[k];
        req_valid[i] = 1'b1;
      end
    end
    chk_out_valid = 1'b0;
    chk_result = 1'($urandom);
    if (ck_pend) begin
      ck_delay--;
      if (ck_delay <= 0) begin
        chk_out_valid = 1'b1; chk_result = ck_res; ck_pend = 0;
      end
    end else if (stray_en && !job_act && ck_buf.size() == 0 && $urandom_range(0, 7) == 0) begin
      chk_out_valid = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step();
    @(posedge clk);
    #1;
    drive_step();
  endtask

  task automatic run_idle(input int bound, input string nm);
    int n;
    n = 0;
    while ((job_act || req_valid != 0 || jq[0].size() > 0 || jq[1].size() > 0 || ck_pend) && n < bound) begin
      tick();
      n++;
    end
    chk({nm, "_completes"}, n < bound, 1);
    tick();
    tick();
  endtask

  function automatic job_t mk_job(input int c, input int o0, input int o1, input int o2);
    job_t j;
    j.cnt = 4'(c);
    for (int k = 0; k < MC; k++) j.ord[k] = 4'd0;
    j.ord[0] = 4'(o0); j.ord[1] = 4'(o1); j.ord[2] = 4'(o2);
    return j;
  endfunction

  function automatic job_t rand_job(input int cmax);
    job_t j;
    int c, r;
    logic [3:0] t;
    c = int'($urandom_range(0, cmax));
    j.cnt = 4'(c);
    for (int k = 0; k < MC; k++) j.ord[k] = 4'(k + 1);
    if ($urandom_range(0, 1) == 0) begin
      for (int k = c - 1; k > 0; k--) begin
        r = int'($urandom_range(0, k));
        t = j.ord[k]; j.ord[k] = j.ord[r]; j.ord[r] = t;
      end
    end else begin
      for (int k = 0; k < MC; k++) j.ord[k] = 4'($urandom_range(1, (c > 0) ? c : 1));
    end
    return j;
  endfunction

  initial begin
    logic [3:0] q[$];
    logic [15:0] pk;
    job_t j;
    int b;

    // model pins
    q = '{4'd3, 4'd3, 4'd2, 4'd1}; chk("model_321", railway(q), 1);
    q = '{4'd3, 4'd3, 4'd1, 4'd2}; chk("model_312", railway(q), 0);
    q = '{4'd3, 4'd1, 4'd3, 4'd2}; chk("model_132", railway(q), 1);
    q = '{4'd4, 4'd4, 4'd1, 4'd2, 4'd3}; chk("model_4123", railway(q), 0);

    rst_n = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    // single job, achievable order
    dlog.delete();
    jq[0].push_back(mk_job(3, 3, 2, 1));
    ck_lat = 2;
    run_idle(100, "t1");
    pk = 16'h0;
    for (int k = 0; k < 4; k++) pk = {pk[11:0], (k < dlog.size()) ? dlog[k] : 4'hF};
    chk("t1_data_seq", pk, 16'h3321);
    chk("t1_rsp", {last_rv, last_res, last_err}, {2'b01, 1'b1, 1'b0});

    // single job, impossible order
    jq[0].push_back(mk_job(3, 3, 1, 2));
    ck_lat = 0;
    run_idle(100, "t2");
    chk("t2_rsp", {last_rv, last_res, last_err}, {2'b01, 1'b0, 1'b0});

    // rejected jobs from requester 1
    ndata = 0;
    jq[1].push_back(mk_job(0, 1, 2, 3));
    jq[1].push_back(mk_job(11, 1, 2, 3));
    run_idle(100, "t_rej");
    chk("rej_no_traffic", ndata, 0);
    chk("rej_rsp", {last_rv, last_res, last_err}, {2'b10, 1'b0, 1'b1});

    // both requesters continuously valid
    grants.delete();
    seen_job = 0; min_gap = 1000;
    for (int k = 0; k < 4; k++) begin
      jq[0].push_back(rand_job(MC));
      jq[1].push_back(rand_job(MC));
      jq[0][k].cnt = 4'($urandom_range(1, MC));
      jq[1][k].cnt = 4'($urandom_range(1, MC));
    end
    run_idle(400, "t_alt");
    pk = 16'h0;
    for (int k = 0; k < 4; k++) pk = {pk[11:0], (k < grants.size()) ? 4'(grants[k]) : 4'hF};
    chk("alt_grants", pk, 16'h0101);
    chk("alt_gap_ge2", min_gap >= 2, 1);

    // randomized traffic with stray verdict pulses while idle
    stray_en = 1;
    for (int k = 0; k < 12; k++) begin
      jq[0].push_back(rand_job(12));
      jq[1].push_back(rand_job(12));
    end
    run_idle(2000, "t_rand");
    stray_en = 0;

    // checker withholds its verdict
    ck_lat = 100;
    jq[0].push_back(mk_job(2, 2, 1, 0));
    repeat (80) tick();
`ifdef TRAIN_ARB_TIMEOUT_EN
    chk("withhold_busy", busy, 0);
`else
    chk("withhold_busy", busy, 1);
`endif
    run_idle(300, "t_withhold");
`ifdef TRAIN_ARB_TIMEOUT_EN
    chk("withhold_rsp", {last_rv, last_res, last_err}, {2'b01, 1'b0, 1'b1});
`else
    chk("withhold_rsp", {last_rv, last_res, last_err}, {2'b01, 1'b1, 1'b0});
`endif
    ck_lat = 0;

    // reset during the 4th SEND cycle of a 10-car job
    j = mk_job(10, 10, 9, 8);
    for (int k = 3; k < MC; k++) j.ord[k] = 4'(10 - k);
    jq[0].push_back(j);
    ndata = 0;
    b = 0;
    while (ndata < 4 && b < 60) begin
      @(negedge clk);
      mon_step();
      if (ndata < 4) begin
        @(posedge clk);
        #1;
        drive_step();
      end
      b++;
    end
    chk("rst_reached_send", ndata, 4);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs_now", {req_ready, rsp_valid, rsp_result, rsp_err, busy, chk_in_valid, chk_data}, 0);
    @(posedge clk);
    #1;
    drive_step();
    tick();
    tick();
    rst_n = 1'b1;
    grants.delete();
    jq[1].push_back(mk_job(3, 1, 2, 3));
    jq[0].push_back(mk_job(3, 3, 2, 1));
    run_idle(200, "t_after_rst");
    chk("after_rst_first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    chk("after_rst_grant_count", grants.size(), 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "global timeout");
  end

endmodule
